// File: rtl/kc705_pcie_rst_seq_pkg.sv
// Shared definitions for the KC705 PCIe reset sequencer: state encodings,
// status LED bit positions and a small state-decode helper.
package kc705_pcie_rst_seq_pkg;

   localparam int SEQ_STATE_W = 3;

   typedef enum logic [SEQ_STATE_W-1:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_PERST     = 3'd3,
      ST_WAIT_USER = 3'd4,
      ST_RUN       = 3'd5,
      ST_FAULT     = 3'd6
   } seq_state_e;

   localparam int LED_STATE_LSB = 0;
   localparam int LED_PERST     = 3;
   localparam int LED_USER      = 4;
   localparam int LED_FAULT     = 5;
   localparam int LED_HB_LSB    = 6;

   function automatic logic perst_released(input seq_state_e st);
      return (st == ST_WAIT_USER) || (st == ST_RUN);
   endfunction

endpackage

// File: rtl/kc705_pcie_rst_seq_sync_2ff.sv
// Single-bit two-flop synchroniser for slow asynchronous status inputs;
// output resets to 0 so a missing input reads as "not ready".
module kc705_sync_2ff (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/kc705_pcie_rst_seq.sv
// Power-up sequencer releasing PCIe PERST# and user reset once DDR and MMCM are stable.
// Optional LED heartbeat is built when KC705_RST_SEQ_HEARTBEAT_EN is defined.
module kc705_pcie_rst_seq
   import kc705_pcie_rst_seq_pkg::*;
#(
   parameter int CNT_W         = 24,
   parameter int STABLE_CYCLES = 1024,
   parameter int LOCK_TIMEOUT  = 16777215,
   parameter int PERST_HOLD    = 10000,
   parameter int USER_DELAY    = 256,
   parameter int MAX_RETRY     = 3
) (
   input  logic                   ddr_clk_100MHz,
   input  logic                   ext_sys_rst_n,
   input  logic                   ddr_rdy,
   input  logic                   pcie_mmcm_locked,
   input  logic                   soft_rst_req,
   output logic                   pcie_perst_n,
   output logic                   user_rst_n,
   output logic                   mmcms_locked,
   output logic [SEQ_STATE_W-1:0] seq_state,
   output logic                   fault,
   output logic [3:0]             retry_cnt,
   output logic [7:0]             status_leds
);

   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] PERST_LAST   = CNT_W'(PERST_HOLD - 1);
   localparam logic [CNT_W-1:0] USER_LAST    = CNT_W'(USER_DELAY - 1);
   localparam logic [CNT_W-1:0] CNT_MAX      = '1;
   localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);
   localparam longint           CNT_SPAN     = longint'(1) << CNT_W;

   logic       ddr_rdy_sync;
   logic       mmcm_locked_sync;
   logic       lock_ok;
   logic [1:0] hb_leds;

   seq_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       retry_q, retry_d;
   logic             fault_q;
   logic             perst_n_q;
   logic             user_rst_n_q;
   logic             locked_q;

   kc705_sync_2ff u_sync_ddr (
      .clk_i   (ddr_clk_100MHz),
      .rst_n_i (ext_sys_rst_n),
      .d_i     (ddr_rdy),
      .q_o     (ddr_rdy_sync)
   );

   kc705_sync_2ff u_sync_mmcm (
      .clk_i   (ddr_clk_100MHz),
      .rst_n_i (ext_sys_rst_n),
      .d_i     (pcie_mmcm_locked),
      .q_o     (mmcm_locked_sync)
   );

   assign lock_ok = ddr_rdy_sync & mmcm_locked_sync;

   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: state_d = ST_WAIT_LOCK;
         ST_WAIT_LOCK: begin
            if (lock_ok) begin
               state_d = ST_STABLE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               retry_d = retry_q + 4'd1;
               state_d = (retry_d == RETRY_LIMIT) ? ST_FAULT : ST_IDLE;
            end
         end
         ST_STABLE: begin
            if (!lock_ok)                  state_d = ST_WAIT_LOCK;
            else if (cnt_q == STABLE_LAST) state_d = ST_PERST;
         end
         ST_PERST: begin
            if (!lock_ok)                 state_d = ST_IDLE;
            else if (cnt_q == PERST_LAST) state_d = ST_WAIT_USER;
         end
         ST_WAIT_USER: begin
            if (!lock_ok)                state_d = ST_IDLE;
            else if (cnt_q == USER_LAST) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!lock_ok || soft_rst_req) state_d = ST_IDLE;
         end
         ST_FAULT: begin
            if (soft_rst_req) begin
               state_d = ST_IDLE;
               retry_d = 4'd0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if ((state_d == ST_RUN) && (state_q != ST_RUN)) retry_d = 4'd0;

      // Saturate rather than wrap so long RUN/FAULT residency never aliases a terminal count.
      if (state_d != state_q)   cnt_d = '0;
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge ddr_clk_100MHz or negedge ext_sys_rst_n) begin
      if (!ext_sys_rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         retry_q      <= 4'd0;
         fault_q      <= 1'b0;
         perst_n_q    <= 1'b0;
         user_rst_n_q <= 1'b0;
         locked_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         retry_q      <= retry_d;
         fault_q      <= (state_d == ST_FAULT);
         perst_n_q    <= perst_released(state_d);
         user_rst_n_q <= (state_d == ST_RUN);
         locked_q     <= lock_ok;
      end
   end

   always_ff @(posedge ddr_clk_100MHz) begin
      assert (CNT_W >= 1 && CNT_W <= 32)
         else $error("kc705_pcie_rst_seq: CNT_W out of range");
      assert (STABLE_CYCLES >= 1 && longint'(STABLE_CYCLES) < CNT_SPAN)
         else $error("kc705_pcie_rst_seq: STABLE_CYCLES out of range");
      assert (LOCK_TIMEOUT >= 1 && longint'(LOCK_TIMEOUT) < CNT_SPAN)
         else $error("kc705_pcie_rst_seq: LOCK_TIMEOUT out of range");
      assert (PERST_HOLD >= 1 && longint'(PERST_HOLD) < CNT_SPAN)
         else $error("kc705_pcie_rst_seq: PERST_HOLD out of range");
      assert (USER_DELAY >= 1 && longint'(USER_DELAY) < CNT_SPAN)
         else $error("kc705_pcie_rst_seq: USER_DELAY out of range");
      assert (MAX_RETRY >= 1 && MAX_RETRY <= 15)
         else $error("kc705_pcie_rst_seq: MAX_RETRY out of range");
   end

`ifdef KC705_RST_SEQ_HEARTBEAT_EN
   logic [25:0] hb_cnt_q;

   always_ff @(posedge ddr_clk_100MHz or negedge ext_sys_rst_n) begin
      if (!ext_sys_rst_n) hb_cnt_q <= '0;
      else                hb_cnt_q <= hb_cnt_q + 26'd1;
   end

   assign hb_leds = hb_cnt_q[25:24];
`else
   assign hb_leds = 2'b00;
`endif

   always_comb begin
      status_leds = '0;
      status_leds[LED_STATE_LSB +: SEQ_STATE_W] = state_q;
      status_leds[LED_PERST]                    = perst_n_q;
      status_leds[LED_USER]                     = user_rst_n_q;
      status_leds[LED_FAULT]                    = fault_q;
      status_leds[LED_HB_LSB +: 2]              = hb_leds;
   end

   assign pcie_perst_n = perst_n_q;
   assign user_rst_n   = user_rst_n_q;
   assign mmcms_locked = locked_q;
   assign seq_state    = state_q;
   assign fault        = fault_q;
   assign retry_cnt    = retry_q;

endmodule
